led_sequencer: RTL and testbench



---
 rtl/led_seq_pkg.sv | 32 +++
 rtl/tick_prescaler.sv | 26 ++
 rtl/led_sequencer.sv | 117 +++++++++++
 tb/tb_led_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared mode, start-pattern and direction definitions for the LED sequencer.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT  = 2'd0,
    MODE_WALK   = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  localparam logic [3:0] START_COUNT  = 4'b0000;
  localparam logic [3:0] START_WALK   = 4'b0001;
  localparam logic [3:0] START_BOUNCE = 4'b0001;
  localparam logic [3:0] START_BLINK  = 4'b1111;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  function automatic logic [3:0] start_pattern(input mode_e mode);
    case (mode)
      MODE_COUNT:  return START_COUNT;
      MODE_WALK:   return START_WALK;
      MODE_BOUNCE: return START_BOUNCE;
      default:     return START_BLINK;
    endcase
  endfunction

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Synchronous prescaler: tick is high in a cycle whose edge ends a DIV+1 period.
module tick_prescaler #(
  parameter int DIV_W = 24
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [DIV_W-1:0] DIV,
  input  logic             PAUSE,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  // >= rather than == so a DIV lowered below cnt fires at once instead of wrapping.
  assign tick = !PAUSE && (cnt >= DIV);

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
    end else if (!PAUSE) begin
      if (cnt >= DIV) cnt <= '0;
      else            cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// LED pattern sequencer advanced by a prescaler tick; four display modes.
// Optional PWM dimming with a DUTY input when LED_SEQ_DIM_EN is defined.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int         DIV_W    = 24,
  parameter logic [1:0] RST_MODE = 2'd0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [DIV_W-1:0] DIV,
  input  logic [1:0]       MODE,
  input  logic             PAUSE,
`ifdef LED_SEQ_DIM_EN
  input  logic [7:0]       DUTY,
`endif
  output logic             TICK,
  output logic [3:0]       LED,
  output logic [2:0]       fsm_state
);

  logic       tick;
  mode_e      mode_req, mode_r, mode_nxt;
  logic       dir_r, dir_nxt;
  logic [3:0] led_r, led_nxt;
  logic       tick_r;

  tick_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .CLK   (CLK),
    .RST   (RST),
    .DIV   (DIV),
    .PAUSE (PAUSE),
    .tick  (tick)
  );

  assign mode_req = mode_e'(MODE);

  // State register: TICK is registered alongside the pattern so both change together.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mode_r <= mode_e'(RST_MODE);
      dir_r  <= DIR_LEFT;
      led_r  <= 4'b0000;
      tick_r <= 1'b0;
    end else begin
      tick_r <= tick;
      if (tick) begin
        mode_r <= mode_nxt;
        dir_r  <= dir_nxt;
        led_r  <= led_nxt;
      end
    end
  end

  // Next-state logic, only consumed on a tick.
  always_comb begin
    mode_nxt = mode_r;
    dir_nxt  = dir_r;
    led_nxt  = led_r;
    if (mode_req != mode_r) begin
      mode_nxt = mode_req;
      led_nxt  = start_pattern(mode_req);
      dir_nxt  = DIR_LEFT;
    end else begin
      case (mode_r)
        MODE_COUNT: led_nxt = led_r + 4'd1;
        MODE_WALK: begin
          if (!is_onehot(led_r)) led_nxt = START_WALK;
          else                   led_nxt = {led_r[2:0], led_r[3]};
        end
        MODE_BOUNCE: begin
          if (!is_onehot(led_r)) begin
            led_nxt = START_BOUNCE;
            dir_nxt = DIR_LEFT;
          end else if (dir_r == DIR_LEFT) begin
            if (led_r == 4'b1000) begin
              led_nxt = 4'b0100;
              dir_nxt = DIR_RIGHT;
            end else begin
              led_nxt = led_r << 1;
            end
          end else begin
            if (led_r == 4'b0001) begin
              led_nxt = 4'b0010;
              dir_nxt = DIR_LEFT;
            end else begin
              led_nxt = led_r >> 1;
            end
          end
        end
        MODE_BLINK: led_nxt = ~led_r;
      endcase
    end
  end

`ifdef LED_SEQ_DIM_EN
  logic [7:0] pwm;

  always_ff @(posedge CLK) begin
    if (RST) pwm <= 8'd0;
    else     pwm <= pwm + 8'd1;
  end

  always_comb begin
    LED       = led_r & {4{pwm < DUTY}};
    TICK      = tick_r;
    fsm_state = {mode_r, dir_r};
  end
`else
  always_comb begin
    LED       = led_r;
    TICK      = tick_r;
    fsm_state = {mode_r, dir_r};
  end
`endif

endmodule

// File: tb/tb_led_sequencer.sv
// Randomized and directed bench for led_sequencer against a pattern-index reference model.
module tb_led_sequencer;

  localparam int DIV_W = 24;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic [DIV_W-1:0] DIV = '0;
  logic [1:0]       MODE = 2'd0;
  logic             PAUSE = 1'b0;
`ifdef LED_SEQ_DIM_EN
  logic [7:0]       DUTY = 8'd255;
`endif
  logic             TICK;
  logic [3:0]       LED;
  logic [2:0]       fsm_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [6:0] exp_q[$];

  // Reference model: each mode kept as a position in its own pattern sequence.
  int m_cnt = 0;
  int m_mode = 0;
  int m_count_val = 0;
  int m_walk_pos = 0;
  int m_bounce_idx = 0;
  bit m_blink_on = 1'b0;
  bit m_tick = 1'b0;
  int m_pwm = 0;
  int bounce_seq[6] = '{1, 2, 4, 8, 4, 2};

  always #5 CLK = ~CLK;

  led_sequencer #(.DIV_W(DIV_W), .RST_MODE(2'd0)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .DIV       (DIV),
    .MODE      (MODE),
    .PAUSE     (PAUSE),
`ifdef LED_SEQ_DIM_EN
    .DUTY      (DUTY),
`endif
    .TICK      (TICK),
    .LED       (LED),
    .fsm_state (fsm_state)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_led();
    case (m_mode)
      0:       return 4'(m_count_val % 16);
      1:       return 4'(1 << m_walk_pos);
      2:       return 4'(bounce_seq[m_bounce_idx]);
      default: return m_blink_on ? 4'hF : 4'h0;
    endcase
  endfunction

  function automatic logic [3:0] model_out();
    logic [3:0] v;
    v = model_led();
`ifdef LED_SEQ_DIM_EN
    if (!(m_pwm < int'(DUTY))) v = 4'h0;
`endif
    return v;
  endfunction

  task automatic model_tick();
    if (int'(MODE) != m_mode) begin
      m_mode       = int'(MODE);
      m_count_val  = 0;
      m_walk_pos   = 0;
      m_bounce_idx = 0;
      m_blink_on   = 1'b1;
    end else begin
      m_count_val  = (m_count_val + 1) % 16;
      m_walk_pos   = (m_walk_pos + 1) % 4;
      m_bounce_idx = (m_bounce_idx + 1) % 6;
      m_blink_on   = !m_blink_on;
    end
  endtask

  task automatic model_step();
    if (RST) begin
      m_cnt = 0; m_mode = 0; m_count_val = 0; m_walk_pos = 0;
      m_bounce_idx = 0; m_blink_on = 1'b0; m_tick = 1'b0; m_pwm = 0;
    end else begin
      m_pwm  = (m_pwm + 1) % 256;
      m_tick = 1'b0;
      if (!PAUSE) begin
        if (m_cnt >= int'(DIV)) begin
          m_cnt  = 0;
          m_tick = 1'b1;
          model_tick();
        end else begin
          m_cnt++;
        end
      end
    end
  endtask

  // One clock: advance model with current inputs, then compare just after the edge.
  task automatic step();
    logic [6:0] e;
    model_step();
    exp_q.push_back({2'(m_mode), m_tick, model_out()});
    @(posedge CLK);
    #1;
    e = exp_q.pop_front();
    check_eq("tick", 32'(TICK), 32'(e[4]));
    check_eq("led", 32'(LED), 32'(e[3:0]));
    check_eq("mode_r", 32'(fsm_state[2:1]), 32'(e[6:5]));
  endtask

  task automatic run_to_tick(input string tag, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!TICK && n < 300);
    if (!TICK) check_eq({tag, "_timeout"}, 32'(TICK), 32'd1);
  endtask

  initial begin
    int first_tick;
    int n;
    logic [3:0] held;
    logic [3:0] bounce_exp[8];
    bounce_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};

    // Reset, then count mode with DIV=3
    RST = 1'b1; DIV = 24'd3; MODE = 2'd0; PAUSE = 1'b0;
    step(); step();
    check_eq("rst_led", 32'(LED), 32'h0);
    check_eq("rst_tick", 32'(TICK), 32'h0);
    check_eq("rst_state", 32'(fsm_state), 32'h0);
    RST = 1'b0;
    first_tick = -1;
    for (int c = 1; c <= 70; c++) begin
      step();
      if (TICK && first_tick < 0) first_tick = c;
      if (c == 4)  check_eq("count_first", 32'(LED), 32'h1);
      if (c == 12) check_eq("count_third", 32'(LED), 32'h3);
      if (c == 64) check_eq("count_wrap", 32'(LED), 32'h0);
    end
    check_eq("first_tick_cycle", 32'(first_tick), 32'd4);

    // Bounce at one tick per cycle
    MODE = 2'd2; DIV = 24'd0;
    for (int i = 0; i < 8; i++) begin
      step();
      check_eq("bounce_seq", 32'(LED), 32'(bounce_exp[i]));
    end

    // Walk to 0100, then request blink mid-period
    MODE = 2'd1; DIV = 24'd9;
    n = 0;
    do begin step(); n++; end while (!(model_led() == 4'b0100 && m_tick) && n < 200);
    check_eq("walk_0100", 32'(LED), 32'h4);
    step(); step(); step();
    MODE = 2'd3;
    run_to_tick("blink1", n);
    check_eq("blink_start", 32'(LED), 32'hF);
    check_eq("blink_wait", 32'(n), 32'd7);
    run_to_tick("blink2", n);
    check_eq("blink_off", 32'(LED), 32'h0);
    run_to_tick("blink3", n);
    check_eq("blink_on", 32'(LED), 32'hF);

    // Pause at cnt=2 with DIV=5
    DIV = 24'd5;
    n = 0;
    do begin step(); n++; end while (m_cnt != 2 && n < 50);
    held = LED;
    PAUSE = 1'b1;
    repeat (20) step();
    check_eq("pause_led_hold", 32'(LED), 32'(held));
    PAUSE = 1'b0;
    run_to_tick("pause_release", n);
    check_eq("pause_release_cycles", 32'(n), 32'd4);

    // Lower DIV below a running count
    DIV = 24'd100;
    n = 0;
    do begin step(); n++; end while (m_cnt != 50 && n < 250);
    DIV = 24'd2;
    step();
    check_eq("div_lower_tick", 32'(TICK), 32'd1);

    // Reset mid-bounce while paused
    MODE = 2'd2; DIV = 24'd1;
    repeat (9) step();
    PAUSE = 1'b1; RST = 1'b1;
    step();
    check_eq("midrst_led", 32'(LED), 32'h0);
    check_eq("midrst_tick", 32'(TICK), 32'h0);
    check_eq("midrst_mode", 32'(fsm_state[2:1]), 32'h0);
    RST = 1'b0; PAUSE = 1'b0;
    run_to_tick("midrst_first", n);
    check_eq("midrst_first_cycles", 32'(n), 32'd2);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) MODE = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) DIV = DIV_W'($urandom_range(0, 6));
      PAUSE = ($urandom_range(0, 9) == 0);
      RST   = ($urandom_range(0, 199) == 0);
      step();
    end
    RST = 1'b0; PAUSE = 1'b0;

`ifdef LED_SEQ_DIM_EN
    MODE = 2'd3; DIV = 24'd0; DUTY = 8'd255;
    n = 0;
    do begin step(); n++; end while (!(m_mode == 3 && m_blink_on) && n < 10);
    DIV = 24'd5000; DUTY = 8'd64;
    repeat (256) step();
    DUTY = 8'd0; DIV = 24'd2;
    repeat (20) step();
    check_eq("dim_off", 32'(LED), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
